// File: rtl/ad9363_rx_delay_cal.sv
// Receive IDELAY tap calibration for the AD9363 interface: sweeps all 32 taps against the
// BIST ramp, loads the centre of the widest passing window, then monitors pattern lock.
module ad9363_rx_delay_cal #(
    parameter int LD_CYCLES      = 4,
    parameter int SETTLE_CYCLES  = 64,
    parameter int CHECK_LEN      = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        rx_clk_bufg,
    input  logic        rst,
    input  logic        cal_start,
    input  logic        adc_valid,
    input  logic [11:0] adc_data_i1,
    input  logic [11:0] adc_data_q1,
    output logic [4:0]  delay_value,
    output logic        delay_load_en,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_ok,
    output logic [31:0] pass_map,
    output logic [4:0]  best_tap,
    output logic [5:0]  win_len,
    output logic        rx_status
);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, NEXT, EVAL, APPLY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  tap_reg, tap_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [15:0] good_cnt_reg, good_cnt_next;
    logic [11:0] prev_i_reg, prev_i_next;
    logic        seeded_reg, seeded_next;
    logic        tap_pass_reg, tap_pass_next;
    logic [4:0]  idx_reg, idx_next;
    logic [4:0]  run_start_reg, run_start_next;
    logic [5:0]  run_len_reg, run_len_next;
    logic [4:0]  best_start_reg, best_start_next;
    logic [5:0]  best_len_reg, best_len_next;
    logic [4:0]  delay_value_reg, delay_value_next;
    logic        load_en_reg, load_en_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        ok_reg, ok_next;
    logic [31:0] pass_map_reg, pass_map_next;
    logic [4:0]  best_tap_reg, best_tap_next;
    logic [5:0]  win_len_reg, win_len_next;
    logic        rx_status_reg, rx_status_next;

    logic        sample_good;
    logic        chk_decided;
    logic        chk_pass;
    logic [5:0]  half_len;

    assign sample_good = (adc_data_q1 == adc_data_i1) && (adc_data_i1 == prev_i_reg + 12'd1);

    always_ff @(posedge rx_clk_bufg) begin
        if (rst) begin
            state_reg       <= IDLE;
            tap_reg         <= '0;
            cnt_reg         <= '0;
            good_cnt_reg    <= '0;
            prev_i_reg      <= '0;
            seeded_reg      <= 1'b0;
            tap_pass_reg    <= 1'b0;
            idx_reg         <= '0;
            run_start_reg   <= '0;
            run_len_reg     <= '0;
            best_start_reg  <= '0;
            best_len_reg    <= '0;
            delay_value_reg <= '0;
            load_en_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            ok_reg          <= 1'b0;
            pass_map_reg    <= '0;
            best_tap_reg    <= '0;
            win_len_reg     <= '0;
            rx_status_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tap_reg         <= tap_next;
            cnt_reg         <= cnt_next;
            good_cnt_reg    <= good_cnt_next;
            prev_i_reg      <= prev_i_next;
            seeded_reg      <= seeded_next;
            tap_pass_reg    <= tap_pass_next;
            idx_reg         <= idx_next;
            run_start_reg   <= run_start_next;
            run_len_reg     <= run_len_next;
            best_start_reg  <= best_start_next;
            best_len_reg    <= best_len_next;
            delay_value_reg <= delay_value_next;
            load_en_reg     <= load_en_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            ok_reg          <= ok_next;
            pass_map_reg    <= pass_map_next;
            best_tap_reg    <= best_tap_next;
            win_len_reg     <= win_len_next;
            rx_status_reg   <= rx_status_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        tap_next         = tap_reg;
        cnt_next         = cnt_reg;
        good_cnt_next    = good_cnt_reg;
        prev_i_next      = prev_i_reg;
        seeded_next      = seeded_reg;
        tap_pass_next    = tap_pass_reg;
        idx_next         = idx_reg;
        run_start_next   = run_start_reg;
        run_len_next     = run_len_reg;
        best_start_next  = best_start_reg;
        best_len_next    = best_len_reg;
        delay_value_next = delay_value_reg;
        load_en_next     = load_en_reg;
        busy_next        = busy_reg;
        done_next        = done_reg;
        ok_next          = ok_reg;
        pass_map_next    = pass_map_reg;
        best_tap_next    = best_tap_reg;
        win_len_next     = win_len_reg;
        rx_status_next   = 1'b0;
        chk_decided      = 1'b0;
        chk_pass         = 1'b0;
        half_len         = '0;

        case (state_reg)
            LOAD: begin
                if (cnt_reg == 32'(LD_CYCLES - 1)) begin
                    load_en_next = 1'b0;
                    cnt_next     = '0;
                    state_next   = SETTLE;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            SETTLE: begin
                if (cnt_reg == 32'(SETTLE_CYCLES - 1)) begin
                    cnt_next      = '0;
                    good_cnt_next = '0;
                    seeded_next   = 1'b0;
                    state_next    = CHECK;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            CHECK: begin
                cnt_next = cnt_reg + 32'd1;
                if (adc_valid) begin
                    prev_i_next = adc_data_i1;
                    if (!seeded_reg) begin
                        seeded_next = 1'b1;
                    end else if (!sample_good) begin
                        chk_decided = 1'b1;
                    end else if (good_cnt_reg == 16'(CHECK_LEN - 1)) begin
                        chk_decided = 1'b1;
                        chk_pass    = 1'b1;
                    end else begin
                        good_cnt_next = good_cnt_reg + 16'd1;
                    end
                end
                if (cnt_reg == 32'(TIMEOUT_CYCLES - 1)) begin
                    chk_decided = 1'b1;
                end
                if (chk_decided) begin
                    tap_pass_next = chk_pass;
                    state_next    = NEXT;
                end
            end
            NEXT: begin
                pass_map_next[tap_reg] = tap_pass_reg;
                if (tap_reg == 5'd31) begin
                    idx_next        = '0;
                    run_start_next  = '0;
                    run_len_next    = '0;
                    best_start_next = '0;
                    best_len_next   = '0;
                    state_next      = EVAL;
                end else begin
                    tap_next         = tap_reg + 5'd1;
                    delay_value_next = tap_reg + 5'd1;
                    load_en_next     = 1'b1;
                    cnt_next         = '0;
                    state_next       = LOAD;
                end
            end
            EVAL: begin
                // Strict '>' keeps the earliest of equally long runs.
                if (pass_map_reg[idx_reg]) begin
                    run_len_next   = run_len_reg + 6'd1;
                    run_start_next = (run_len_reg == 6'd0) ? idx_reg : run_start_reg;
                    if (run_len_next > best_len_reg) begin
                        best_len_next   = run_len_next;
                        best_start_next = run_start_next;
                    end
                end else begin
                    run_len_next = '0;
                end
                idx_next = idx_reg + 5'd1;
                if (idx_reg == 5'd31) begin
                    if (best_len_next != 6'd0) begin
                        half_len      = (best_len_next - 6'd1) >> 1;
                        best_tap_next = best_start_next + half_len[4:0];
                    end else begin
                        best_tap_next = '0;
                    end
                    win_len_next     = best_len_next;
                    ok_next          = (best_len_next != 6'd0);
                    delay_value_next = best_tap_next;
                    load_en_next     = 1'b1;
                    cnt_next         = '0;
                    state_next       = APPLY;
                end
            end
            APPLY: begin
                if (cnt_reg == 32'(LD_CYCLES - 1)) begin
                    load_en_next = 1'b0;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    seeded_next  = 1'b0;
                    state_next   = DONE;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            DONE: begin
                rx_status_next = rx_status_reg;
                if (adc_valid) begin
                    prev_i_next = adc_data_i1;
                    if (!seeded_reg) begin
                        seeded_next = 1'b1;
                    end else begin
                        rx_status_next = sample_good && ok_reg;
                    end
                end
            end
            default: ;
        endcase

        if (cal_start && (state_reg == IDLE || state_reg == DONE)) begin
            state_next       = LOAD;
            tap_next         = '0;
            cnt_next         = '0;
            delay_value_next = '0;
            load_en_next     = 1'b1;
            busy_next        = 1'b1;
            done_next        = 1'b0;
            ok_next          = 1'b0;
            pass_map_next    = '0;
            best_tap_next    = '0;
            win_len_next     = '0;
            rx_status_next   = 1'b0;
        end
    end

    assign delay_value   = delay_value_reg;
    assign delay_load_en = load_en_reg;
    assign cal_busy      = busy_reg;
    assign cal_done      = done_reg;
    assign cal_ok        = ok_reg;
    assign pass_map      = pass_map_reg;
    assign best_tap      = best_tap_reg;
    assign win_len       = win_len_reg;
    assign rx_status     = rx_status_reg;

endmodule

// File: tb/tb_ad9363_rx_delay_cal.sv
// Directed bench for ad9363_rx_delay_cal: a ramp source whose per-tap quality is set by a
// mask stands in for the PHY; each task checks one scenario with hand-computed values.
module tb_ad9363_rx_delay_cal;

    logic        clk;
    logic        rst;
    logic        cal_start;
    logic        adc_valid;
    logic [11:0] adc_data_i1;
    logic [11:0] adc_data_q1;
    logic [4:0]  delay_value;
    logic        delay_load_en;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_ok;
    logic [31:0] pass_map;
    logic [4:0]  best_tap;
    logic [5:0]  win_len;
    logic        rx_status;

    int checks = 0;
    int errors = 0;

    logic        gen_on = 1'b0;
    logic [31:0] pass_mask = 32'hFFFF_FFFF;
    logic        inject = 1'b0;
    logic [11:0] ramp = 12'd100;
    logic        phase = 1'b0;

    ad9363_rx_delay_cal #(
        .LD_CYCLES(4), .SETTLE_CYCLES(8), .CHECK_LEN(8), .TIMEOUT_CYCLES(40)
    ) dut (
        .rx_clk_bufg(clk), .rst(rst), .cal_start(cal_start), .adc_valid(adc_valid),
        .adc_data_i1(adc_data_i1), .adc_data_q1(adc_data_q1), .delay_value(delay_value),
        .delay_load_en(delay_load_en), .cal_busy(cal_busy), .cal_done(cal_done),
        .cal_ok(cal_ok), .pass_map(pass_map), .best_tap(best_tap), .win_len(win_len),
        .rx_status(rx_status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ramp source: a sample every other cycle; taps outside pass_mask get Q bit 0 stuck high.
    initial begin
        adc_valid   = 1'b0;
        adc_data_i1 = '0;
        adc_data_q1 = '0;
        forever begin
            @(negedge clk);
            if (gen_on && phase) begin
                adc_valid = 1'b1;
                if (inject) begin
                    adc_data_i1 = ramp + 12'd1;
                    ramp        = ramp + 12'd2;
                    inject      = 1'b0;
                end else begin
                    adc_data_i1 = ramp;
                    ramp        = ramp + 12'd1;
                end
                adc_data_q1 = pass_mask[delay_value] ? adc_data_i1 : (adc_data_i1 | 12'd1);
            end else begin
                adc_valid = 1'b0;
            end
            phase = ~phase;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (cal_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input logic [31:0] exp_map,
                                input logic [4:0] exp_best, input logic [5:0] exp_len,
                                input logic exp_ok);
        bit ok;
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s done_timeout cal_done=%b required 1", name, cal_done);
        end
        checks++;
        if (pass_map !== exp_map) begin
            errors++;
            $display("FAIL %s pass_map got %h required %h", name, pass_map, exp_map);
        end
        checks++;
        if (best_tap !== exp_best) begin
            errors++;
            $display("FAIL %s best_tap got %0d required %0d", name, best_tap, exp_best);
        end
        checks++;
        if (win_len !== exp_len) begin
            errors++;
            $display("FAIL %s win_len got %0d required %0d", name, win_len, exp_len);
        end
        checks++;
        if (cal_ok !== exp_ok || cal_busy !== 1'b0 || delay_value !== exp_best) begin
            errors++;
            $display("FAIL %s ok/busy/value got %b/%b/%0d required %b/0/%0d",
                     name, cal_ok, cal_busy, delay_value, exp_ok, exp_best);
        end
        $display("%s: map=%h best=%0d len=%0d ok=%b", name, pass_map, best_tap, win_len, cal_ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cal_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({delay_value, delay_load_en, cal_busy, cal_done, cal_ok, pass_map, best_tap,
             win_len, rx_status} !== '0) begin
            errors++;
            $display("FAIL reset outputs got val=%0d ld=%b busy=%b done=%b ok=%b map=%h best=%0d len=%0d st=%b required all 0",
                     delay_value, delay_load_en, cal_busy, cal_done, cal_ok, pass_map, best_tap, win_len, rx_status);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: outputs cleared");
    endtask

    task automatic test_clean_sweep();
        int width;
        pass_mask = 32'hFFFF_FFFF;
        gen_on    = 1'b1;
        repeat (4) @(negedge clk);
        pulse_start();
        checks++;
        if (cal_busy !== 1'b1 || delay_load_en !== 1'b1 || delay_value !== 5'd0) begin
            errors++;
            $display("FAIL start_latency busy/ld/val got %b/%b/%0d required 1/1/0",
                     cal_busy, delay_load_en, delay_value);
        end
        width = 0;
        while (delay_load_en && width < 20) begin
            width++;
            @(negedge clk);
        end
        checks++;
        if (width != 4) begin
            errors++;
            $display("FAIL load_width got %0d required 4", width);
        end
        check_result("clean", 32'hFFFF_FFFF, 5'd15, 6'd32, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if (rx_status !== 1'b1) begin
            errors++;
            $display("FAIL clean_rx_status got %b required 1", rx_status);
        end
    endtask

    task automatic test_inject();
        bit seen = 1'b0;
        inject = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            if (!inject) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL inject_timeout inject=%b required 0", inject);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rx_status !== 1'b0) begin
            errors++;
            $display("FAIL inject_fall got %b required 0", rx_status);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (rx_status !== 1'b1) begin
            errors++;
            $display("FAIL inject_recover got %b required 1", rx_status);
        end
        $display("inject: rx_status dropped and recovered");
    endtask

    task automatic test_window();
        pass_mask = 32'h001F_FF00;
        pulse_start();
        checks++;
        if (cal_done !== 1'b0 || cal_busy !== 1'b1 || rx_status !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_done done/busy/st got %b/%b/%b required 0/1/0",
                     cal_done, cal_busy, rx_status);
        end
        check_result("window", 32'h001F_FF00, 5'd14, 6'd13, 1'b1);
    endtask

    task automatic test_tie();
        pass_mask = 32'h00F0_003C;
        pulse_start();
        check_result("tie", 32'h00F0_003C, 5'd3, 6'd4, 1'b1);
    endtask

    task automatic test_no_valid();
        gen_on = 1'b0;
        pulse_start();
        check_result("no_valid", 32'h0, 5'd0, 6'd0, 1'b0);
        repeat (6) @(negedge clk);
        checks++;
        if (cal_done !== 1'b1 || rx_status !== 1'b0) begin
            errors++;
            $display("FAIL no_valid_status done/st got %b/%b required 1/0", cal_done, rx_status);
        end
        gen_on = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        bit ok;
        pass_mask = 32'hFFFF_FFFF;
        pulse_start();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (delay_value == 5'd17 && delay_load_en) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reach_tap17 delay_value=%0d required 17", delay_value);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({delay_value, delay_load_en, cal_busy, cal_done, cal_ok, pass_map, best_tap,
             win_len, rx_status} !== '0) begin
            errors++;
            $display("FAIL midload_reset got val=%0d ld=%b busy=%b map=%h required all 0",
                     delay_value, delay_load_en, cal_busy, pass_map);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        hit = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (delay_value == 5'd3 && !delay_load_en) begin
                hit = 1'b1;
                break;
            end
        end
        pulse_start();
        checks++;
        if (!hit || delay_value !== 5'd3 || delay_load_en !== 1'b0 || cal_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_ignored val/ld/busy got %0d/%b/%b required 3/0/1",
                     delay_value, delay_load_en, cal_busy);
        end
        wait_done(ok);
        checks++;
        if (!ok || pass_map !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL after_reset_sweep map got %h required ffffffff", pass_map);
        end
        $display("reset_mid: reset in tap 17 load, busy start ignored");
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_inject();
        test_window();
        test_tie();
        test_no_valid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
